// File: rtl/fetch_pkg.sv
// Shared state encoding and default sizes for the PC fetch sequencer.
package fetch_pkg;

  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_ROM_LAT = 1;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    VALID,
    HALTED
  } fetch_state_t;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// ROM read port and downstream instruction handshake of the fetch sequencer.
interface pc_fetch_ctrl_if
  import fetch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr_data;
  logic [ADDR_W-1:0] instr_pc;

  modport master (
    output rom_en, rom_addr, instr_valid, instr_data, instr_pc,
    input  rom_data, instr_ready
  );

  modport slave (
    input  rom_en, rom_addr, instr_valid, instr_data, instr_pc,
    output rom_data, instr_ready
  );

endinterface

// File: rtl/pc_addr_reg.sv
// Program counter register: synchronous reset to START_ADDR, load beats increment,
// increment wraps modulo 2^ADDR_W.
module pc_addr_reg #(
  parameter int                ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] q
);

  // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset)     q <= START_ADDR;
    else if (load) q <= load_val;
    else if (inc)  q <= q + 1'b1;
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads the ROM one word at a time and
// hands each word downstream. Define PC_BREAKPOINT_EN to add a PC breakpoint halt.
module pc_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                ADDR_W     = DEF_ADDR_W,
  parameter int                DATA_W     = DEF_DATA_W,
  parameter int                ROM_LAT    = DEF_ROM_LAT,
  parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              halt_req,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_addr,
`ifdef PC_BREAKPOINT_EN
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  output logic              bp_hit,
`endif
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  pc_fetch_ctrl_if.master   bus
);

  localparam int               CNT_W    = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(ROM_LAT - 1);

  fetch_state_t      state, state_next;
  logic [CNT_W-1:0]  lat_cnt;
  logic              jump_pend, halt_pend;
  logic [ADDR_W-1:0] jump_pend_addr;
  logic              enter_fetch, capture, handshake, busy;
  logic              pc_load, pc_inc;
  logic [ADDR_W-1:0] pc_load_val, fetch_addr;
`ifdef PC_BREAKPOINT_EN
  logic              bp_stop;
`endif

  pc_addr_reg #(
    .ADDR_W     (ADDR_W),
    .START_ADDR (START_ADDR)
  ) u_pc (
    .clk      (clk),
    .reset    (reset),
    .inc      (pc_inc),
    .load     (pc_load),
    .load_val (pc_load_val),
    .q        (pc)
  );

  assign busy = (state == FETCH) || (state == VALID);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    state_next  = state;
    enter_fetch = 1'b0;
    capture     = 1'b0;
    handshake   = 1'b0;
    pc_load     = 1'b0;
    pc_inc      = 1'b0;
    pc_load_val = jump_addr;
    fetch_addr  = pc;
`ifdef PC_BREAKPOINT_EN
    bp_stop     = 1'b0;
`endif
    case (state)
      IDLE, HALTED: begin
        // A jump together with start redirects the very first fetch.
        if (jump_valid) begin
          pc_load    = 1'b1;
          fetch_addr = jump_addr;
        end
        if (start) begin
          enter_fetch = 1'b1;
          state_next  = FETCH;
        end
      end
      FETCH: begin
        if (lat_cnt == '0) begin
          capture    = 1'b1;
          state_next = VALID;
        end
      end
      VALID: begin
        if (bus.instr_ready) begin
          handshake = 1'b1;
          if (jump_valid) begin
            pc_load    = 1'b1;
            fetch_addr = jump_addr;
          end else if (jump_pend) begin
            pc_load     = 1'b1;
            pc_load_val = jump_pend_addr;
            fetch_addr  = jump_pend_addr;
          end else begin
            pc_inc     = 1'b1;
            fetch_addr = pc + 1'b1;
          end
          if (halt_pend || halt_req) begin
            state_next = HALTED;
          end else begin
            enter_fetch = 1'b1;
            state_next  = FETCH;
          end
        end
      end
      default: state_next = IDLE;
    endcase
`ifdef PC_BREAKPOINT_EN
    // A resume out of HALTED must be able to step past the breakpoint.
    if (enter_fetch && (state != HALTED) && bp_en && (fetch_addr == bp_addr)) begin
      enter_fetch = 1'b0;
      bp_stop     = 1'b1;
      state_next  = HALTED;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rom_en      <= 1'b0;
      bus.rom_addr    <= '0;
      bus.instr_valid <= 1'b0;
      bus.instr_data  <= '0;
      bus.instr_pc    <= '0;
      halted          <= 1'b0;
      lat_cnt         <= '0;
      jump_pend       <= 1'b0;
      jump_pend_addr  <= '0;
      halt_pend       <= 1'b0;
    end else begin
      bus.rom_en <= enter_fetch;
      if (enter_fetch) begin
        bus.rom_addr <= fetch_addr;
        lat_cnt      <= LAT_INIT;
      end else if ((state == FETCH) && (lat_cnt != '0)) begin
        lat_cnt <= lat_cnt - 1'b1;
      end

      if (capture) begin
        bus.instr_valid <= 1'b1;
        bus.instr_data  <= bus.rom_data;
        bus.instr_pc    <= pc;
      end else if (handshake) begin
        bus.instr_valid <= 1'b0;
      end

      halted <= (state_next == HALTED);

      // Redirects arriving mid-instruction wait for its handshake; last one wins.
      if (handshake) begin
        jump_pend <= 1'b0;
      end else if (jump_valid && busy) begin
        jump_pend      <= 1'b1;
        jump_pend_addr <= jump_addr;
      end

      if (state_next == HALTED) halt_pend <= 1'b0;
      else if (halt_req && (busy || enter_fetch)) halt_pend <= 1'b1;
    end
  end

`ifdef PC_BREAKPOINT_EN
  always_ff @(posedge clk) begin
    if (reset) bp_hit <= 1'b0;
    else       bp_hit <= bp_stop;
  end
`endif

endmodule
